bira_ctrl: RTL and testbench
============================

# bira_ctrl

Sequencing controller for the BIRA datapath. It classifies each BIST fault report as a pivot or non-pivot fault and issues the matching CAM write. It checks pivot count against available spares and raises early termination. After `test_end` it steps spare-signal candidates through the signal validity checker until a valid one is found or the space is exhausted. It sits between BIST, the CAM storage and the validity checker inside the BIRA top.

## Interface
- `PCAM`, 8, pivot CAM entries
- `NPCAM`, 30, non-pivot CAM entries
- `clk` in 1: 100 MHz system clock
- `rst` in 1: reset, synchronous, active-high
- `spare_struct` in 2: spare structure type
- `fault_detect` in 1: one-cycle fault strobe from BIST
- `test_end` in 1: BIST finished
- `row_add_in`, `col_add_in` in 10 each: fault address
- `bank_in` in 2: fault bank
- `pivot_match` in PCAM: CAM combinational match (row or col, same bank) of presented address vs valid pivots
- `signal_valid` in 1: validity checker result for the current candidate (combinational)
- `cam_wr_en` out 1: CAM write strobe
- `cam_wr_pivot` out 1: 1 = pivot write, 0 = non-pivot write
- `cam_wr_idx` out 5: target entry
- `cam_ptr` out 3: pivot index referenced by a non-pivot write
- `DSSS` out 8, `RLSS` out 4: candidate driven to the checker
- `early_term` out 1: stop BIST
- `done` out 1: analysis finished (level)
- `repair` out 1: repairable; valid only with `done`

## Operation
- States: COLLECT, ANALYZE, DONE. Reset enters COLLECT.
- Reset clears all outputs and counters to 0.
- Spare total by `spare_struct`: 00→4, 01→5, 10→6, 11→8.
- COLLECT, `fault_detect`=1:
  - Effective match is `pivot_match` OR the bypass hit. Bypass hit means the pending (previous-cycle) pivot write has the same bank and the same row or the same col.
  - No match:
    - If `pivot_cnt`<PCAM: pivot write at `pivot_cnt`, then `pivot_cnt`++.
    - Otherwise: set `ovf`.
  - Match:
    - If `np_cnt`<NPCAM: non-pivot write at `np_cnt`, then `np_cnt`++. `cam_ptr` is the lowest matching index. A bypass hit takes precedence and uses the pending index.
    - Otherwise: set `ovf`.
- `ovf`, or `pivot_cnt` exceeding the spare total, makes the fault set unrepairable. See Configuration for how this is handled.
- `test_end` in COLLECT: go to ANALYZE and zero the candidate counter `cand`.
  - If `fault_detect` is asserted in the same cycle, that fault is processed first.
- ANALYZE:
  - `{RLSS,DSSS}` = `cand[11:0]`; one candidate per cycle.
  - `signal_valid`=1: go to DONE with `repair`=1, and freeze DSSS/RLSS.
  - `cand`=4095 with no valid candidate: go to DONE with `repair`=0.
- DONE: `done`=1, all outputs held. `fault_detect` and `test_end` are ignored. Only `rst` leaves this state.
- `fault_detect` is ignored outside COLLECT.

## Timing
- CAM write: `cam_wr_*` are registered and asserted exactly 1 cycle after `fault_detect`, for one cycle.
- The bypass covers back-to-back strobes.
- `early_term` is registered and asserted 1 cycle after the offending fault.
- ANALYZE: the candidate is registered. `signal_valid` is sampled in the same cycle the candidate is presented.
- The DONE transition happens on the next edge. Worst case is 4096 cycles after `test_end`.
- `rst` mid-operation: the next edge gives COLLECT, zero counters, `done`/`repair`/`early_term`=0 and no pending write.

## Configuration
- `BIRA_EARLY_TERM_EN` defined:
  - Unrepairable condition in COLLECT asserts `early_term` (sticky until reset).
  - Controller goes directly to DONE with `repair`=0.
- Not defined:
  - `early_term` is tied 0.
  - Collection continues with further writes suppressed.
  - On `test_end` the controller skips ANALYZE and goes to DONE with `repair`=0.

## Structure
- Package `bira_pkg`:
  - PCAM/NPCAM defaults
  - state enum
  - spare-total function of `spare_struct`
  - candidate width (12)
- One sub-module, `bira_fault_classifier`: bypass compare, match priority encode, pivot/non-pivot decision and counters.
- FSM and candidate counter stay in `bira_ctrl`.

## Test plan
- Reset, `spare_struct`=11; faults (r5,c9,b0), (r5,c20,b0) two cycles apart, with `pivot_match`=01 on the second → pivot write idx0, then non-pivot idx0 ptr0.
- Back-to-back faults (r7,c1,b1), (r300,c1,b1), `pivot_match`=0 → second is non-pivot via bypass, ptr = first pivot idx.
- `spare_struct`=00, five unmatched faults, macro on → `early_term`=1 one cycle after the 5th; `done`=1, `repair`=0.
- Same stimulus with macro off → `early_term`=0; after `test_end`, `done`=1, `repair`=0 with no ANALYZE cycles.
- `test_end`, `signal_valid` forced high when cand=0x02A → DONE, `repair`=1, DSSS=0x2A, RLSS=0.
- `signal_valid` never high → `done` exactly 4096 cycles after entering ANALYZE, `repair`=0; `rst` at cycle 100 of ANALYZE → COLLECT, all outputs 0.

Source files
------------

// File: rtl/bira_pkg.sv
// bira_pkg: shared constants, FSM states and spare-total lookup for the BIRA controller
package bira_pkg;
  localparam int PCAM_DEF = 8;
  localparam int NPCAM_DEF = 30;
  localparam int CAND_W = 12;
  typedef enum logic [1:0] {S_COLLECT, S_ANALYZE, S_DONE} state_t;
  function automatic logic [3:0] spare_total(input logic [1:0] s);
    return s == 2'b00 ? 4'd4 : s == 2'b01 ? 4'd5 : s == 2'b10 ? 4'd6 : 4'd8;
  endfunction
endpackage

// File: rtl/bira_fault_classifier.sv
// bira_fault_classifier: pivot/non-pivot decision with bypass of the pending pivot write, CAM write generation and counters
module bira_fault_classifier import bira_pkg::*; #(
  parameter int PCAM = PCAM_DEF,
  parameter int NPCAM = NPCAM_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic [9:0]      i_row,
  input  logic [9:0]      i_col,
  input  logic [1:0]      i_bank,
  input  logic [PCAM-1:0] i_pivot_match,
  input  logic [3:0]      i_spare_tot,
  output logic            o_wr_en,
  output logic            o_wr_pivot,
  output logic [4:0]      o_wr_idx,
  output logic [2:0]      o_ptr,
  output logic            o_unrep,
  output logic            o_unrep_nxt
);
  logic [3:0] r_pivot_cnt;
  logic [4:0] r_np_cnt;
  logic       r_ovf;
  logic       r_wr_en;
  logic       r_wr_pivot;
  logic [4:0] r_wr_idx;
  logic [2:0] r_ptr;
  logic [9:0] r_p_row;
  logic [9:0] r_p_col;
  logic [1:0] r_p_bank;
  logic [2:0] w_lo;
  logic [2:0] w_ptr;
  logic       w_byp;
  logic       w_match;
  logic       w_wr_piv;
  logic       w_wr_np;
  logic       w_ovf_n;
  logic [3:0] w_pc_n;
  // Classify the presented fault; the write registered last cycle is not yet visible in the CAM, so compare against it directly
  always_comb begin
    w_lo = '0;
    for (int i = PCAM - 1; i >= 0; i--) w_lo = i_pivot_match[i] ? 3'(i) : w_lo;
    w_byp = r_wr_en && r_wr_pivot && i_bank == r_p_bank && (i_row == r_p_row || i_col == r_p_col);
    w_match = w_byp || |i_pivot_match;
    w_ptr = w_byp ? r_wr_idx[2:0] : w_lo;
    w_wr_piv = i_en && !w_match && 32'(r_pivot_cnt) < PCAM;
    w_wr_np = i_en && w_match && 32'(r_np_cnt) < NPCAM;
    w_ovf_n = r_ovf || (i_en && !w_wr_piv && !w_wr_np);
    w_pc_n = r_pivot_cnt + 4'(w_wr_piv);
    o_unrep_nxt = w_ovf_n || w_pc_n > i_spare_tot;
    o_unrep = r_ovf || r_pivot_cnt > i_spare_tot;
  end
  // Register the one-cycle CAM write, counters, overflow flag and the pending pivot address for the bypass
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pivot_cnt <= '0;
      r_np_cnt <= '0;
      r_ovf <= 1'b0;
      r_wr_en <= 1'b0;
      r_wr_pivot <= 1'b0;
      r_wr_idx <= '0;
      r_ptr <= '0;
      r_p_row <= '0;
      r_p_col <= '0;
      r_p_bank <= '0;
    end else begin
      r_ovf <= w_ovf_n;
      r_pivot_cnt <= w_pc_n;
      r_np_cnt <= r_np_cnt + 5'(w_wr_np);
      r_wr_en <= w_wr_piv || w_wr_np;
      r_wr_pivot <= w_wr_piv;
      r_wr_idx <= w_wr_piv ? 5'(r_pivot_cnt) : w_wr_np ? r_np_cnt : 5'd0;
      r_ptr <= w_wr_np ? w_ptr : 3'd0;
      if (w_wr_piv) begin
        r_p_row <= i_row;
        r_p_col <= i_col;
        r_p_bank <= i_bank;
      end
    end
  end
  assign o_wr_en = r_wr_en;
  assign o_wr_pivot = r_wr_pivot;
  assign o_wr_idx = r_wr_idx;
  assign o_ptr = r_ptr;
endmodule

// File: rtl/bira_ctrl.sv
// bira_ctrl: BIRA sequencing FSM (collect, analyze, done) and candidate stepping; BIRA_EARLY_TERM_EN enables early termination
module bira_ctrl import bira_pkg::*; #(
  parameter int PCAM = PCAM_DEF,
  parameter int NPCAM = NPCAM_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      spare_struct,
  input  logic            fault_detect,
  input  logic            test_end,
  input  logic [9:0]      row_add_in,
  input  logic [9:0]      col_add_in,
  input  logic [1:0]      bank_in,
  input  logic [PCAM-1:0] pivot_match,
  input  logic            signal_valid,
  output logic            cam_wr_en,
  output logic            cam_wr_pivot,
  output logic [4:0]      cam_wr_idx,
  output logic [2:0]      cam_ptr,
  output logic [7:0]      DSSS,
  output logic [3:0]      RLSS,
  output logic            early_term,
  output logic            done,
  output logic            repair
);
  state_t            r_state;
  logic [CAND_W-1:0] r_cand;
  logic              r_done;
  logic              r_repair;
  logic              w_en;
  logic              w_unrep;
  logic              w_unrep_nxt;
  assign w_en = fault_detect && r_state == S_COLLECT && !w_unrep;
  bira_fault_classifier #(.PCAM(PCAM), .NPCAM(NPCAM)) u_cls (
    .clk(clk),
    .rst(rst),
    .i_en(w_en),
    .i_row(row_add_in),
    .i_col(col_add_in),
    .i_bank(bank_in),
    .i_pivot_match(pivot_match),
    .i_spare_tot(spare_total(spare_struct)),
    .o_wr_en(cam_wr_en),
    .o_wr_pivot(cam_wr_pivot),
    .o_wr_idx(cam_wr_idx),
    .o_ptr(cam_ptr),
    .o_unrep(w_unrep),
    .o_unrep_nxt(w_unrep_nxt)
  );
`ifdef BIRA_EARLY_TERM_EN
  logic r_early;
  assign early_term = r_early;
`else
  assign early_term = 1'b0;
`endif
  // Controller FSM: collect faults, then step candidates until one is valid or the space is exhausted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_COLLECT;
      r_cand <= '0;
      r_done <= 1'b0;
      r_repair <= 1'b0;
`ifdef BIRA_EARLY_TERM_EN
      r_early <= 1'b0;
`endif
    end else if (r_state == S_COLLECT) begin
`ifdef BIRA_EARLY_TERM_EN
      if (w_unrep_nxt) begin
        r_early <= 1'b1;
        r_state <= S_DONE;
        r_done <= 1'b1;
      end else if (test_end) begin
        r_state <= S_ANALYZE;
        r_cand <= '0;
      end
`else
      if (test_end) begin
        r_state <= w_unrep_nxt ? S_DONE : S_ANALYZE;
        r_done <= w_unrep_nxt;
        r_cand <= '0;
      end
`endif
    end else if (r_state == S_ANALYZE) begin
      if (signal_valid) begin
        r_state <= S_DONE;
        r_done <= 1'b1;
        r_repair <= 1'b1;
      end else if (&r_cand) begin
        r_state <= S_DONE;
        r_done <= 1'b1;
      end else r_cand <= r_cand + 12'd1;
    end
  end
  assign DSSS = r_cand[7:0];
  assign RLSS = r_cand[11:8];
  assign done = r_done;
  assign repair = r_repair;
endmodule

// File: tb/tb_bira_ctrl.sv
// tb_bira_ctrl: directed and randomized checks of bira_ctrl against a behavioural fault-list model
module tb_bira_ctrl;
`ifdef BIRA_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] spare_struct;
  logic       fault_detect;
  logic       test_end;
  logic [9:0] row_add_in;
  logic [9:0] col_add_in;
  logic [1:0] bank_in;
  logic [7:0] pivot_match;
  logic       signal_valid;
  logic       cam_wr_en;
  logic       cam_wr_pivot;
  logic [4:0] cam_wr_idx;
  logic [2:0] cam_ptr;
  logic [7:0] DSSS;
  logic [3:0] RLSS;
  logic       early_term;
  logic       done;
  logic       repair;
  logic       sv_force;
  logic [11:0] sv_tgt;
  int n_chk = 0;
  int n_fail = 0;
  int spare_tab [4] = '{4, 5, 6, 8};
  int mr [8];
  int mc [8];
  int mb [8];
  int npiv;
  int nnp;
  bit ovf;
  bit stop;
  bit prev_pw;
  int prev_idx;
  always #5 clk = ~clk;
  assign signal_valid = sv_force && {RLSS, DSSS} == sv_tgt;
  bira_ctrl dut (
    .clk(clk),
    .rst(rst),
    .spare_struct(spare_struct),
    .fault_detect(fault_detect),
    .test_end(test_end),
    .row_add_in(row_add_in),
    .col_add_in(col_add_in),
    .bank_in(bank_in),
    .pivot_match(pivot_match),
    .signal_valid(signal_valid),
    .cam_wr_en(cam_wr_en),
    .cam_wr_pivot(cam_wr_pivot),
    .cam_wr_idx(cam_wr_idx),
    .cam_ptr(cam_ptr),
    .DSSS(DSSS),
    .RLSS(RLSS),
    .early_term(early_term),
    .done(done),
    .repair(repair)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic all_zero(input string tag);
    chk(tag, {cam_wr_en, cam_wr_pivot, cam_wr_idx, cam_ptr, DSSS, RLSS, early_term, done, repair}, 0);
  endtask
  task automatic do_reset(input logic [1:0] ss);
    rst = 1'b1;
    spare_struct = ss;
    fault_detect = 1'b0;
    test_end = 1'b0;
    row_add_in = '0;
    col_add_in = '0;
    bank_in = '0;
    pivot_match = '0;
    sv_force = 1'b0;
    sv_tgt = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    all_zero("reset");
    npiv = 0;
    nnp = 0;
    ovf = 0;
    stop = 0;
    prev_pw = 0;
    prev_idx = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 chk("idle_wr_en", cam_wr_en, 0);
    end
  endtask
  task automatic fault(input int r, input int c, input int b, input logic [7:0] pm,
                       input logic ee, input logic ep, input int ei, input int eptr);
    row_add_in = 10'(r);
    col_add_in = 10'(c);
    bank_in = 2'(b);
    pivot_match = pm;
    fault_detect = 1'b1;
    @(posedge clk);
    #1 fault_detect = 1'b0;
    pivot_match = '0;
    chk("wr_en", cam_wr_en, ee);
    if (ee) begin
      chk("wr_pivot", cam_wr_pivot, ep);
      chk("wr_idx", cam_wr_idx, ei);
      if (!ep) chk("wr_ptr", cam_ptr, eptr);
    end
  endtask
  task automatic analyze(input int exp_n, input logic exp_rep);
    int n;
    test_end = 1'b1;
    @(posedge clk);
    #1 test_end = 1'b0;
    n = 0;
    while (!done && n < 5000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("an_cycles", n, exp_n);
    chk("done", done, 1);
    chk("repair", repair, exp_rep);
    if (exp_rep) chk("cand", {RLSS, DSSS}, sv_tgt);
  endtask
  task automatic rand_run(input int nf);
    logic [1:0] ss;
    int r, c, b, lo, ptr;
    bit hit, byp;
    logic [7:0] pm;
    ss = 2'($urandom_range(0, 3));
    do_reset(ss);
    for (int k = 0; k < nf; k++) begin
      if ($urandom_range(0, 2) != 0) begin
        idle($urandom_range(1, 2));
        prev_pw = 0;
      end
      r = $urandom_range(0, 7);
      c = $urandom_range(0, 7);
      b = $urandom_range(0, 1);
      pm = '0;
      lo = -1;
      byp = 0;
      for (int i = 0; i < npiv; i++) begin
        hit = mb[i] == b && (mr[i] == r || mc[i] == c);
        if (hit && !(prev_pw && i == prev_idx)) pm[i] = 1'b1;
        if (hit && lo < 0) lo = i;
        if (hit && prev_pw && i == prev_idx) byp = 1;
      end
      if (stop) begin
        fault(r, c, b, pm, 0, 0, 0, 0);
        prev_pw = 0;
      end else if (lo < 0) begin
        if (npiv < 8) begin
          fault(r, c, b, pm, 1, 1, npiv, 0);
          mr[npiv] = r;
          mc[npiv] = c;
          mb[npiv] = b;
          prev_pw = 1;
          prev_idx = npiv;
          npiv++;
        end else begin
          fault(r, c, b, pm, 0, 0, 0, 0);
          ovf = 1;
          prev_pw = 0;
        end
      end else begin
        ptr = byp ? prev_idx : lo;
        if (nnp < 30) begin
          fault(r, c, b, pm, 1, 0, nnp, ptr);
          nnp++;
        end else begin
          fault(r, c, b, pm, 0, 0, 0, 0);
          ovf = 1;
        end
        prev_pw = 0;
      end
      if (ovf || npiv > spare_tab[ss]) stop = 1;
      chk("rnd_early_term", early_term, ET && stop);
      chk("rnd_done", done, ET && stop);
    end
    idle(1);
    sv_force = 1'b1;
    sv_tgt = 12'($urandom_range(0, 300));
    analyze(stop ? 0 : int'(sv_tgt) + 1, !stop);
  endtask
  initial begin
    do_reset(2'b11);
    fault(5, 9, 0, 8'h00, 1, 1, 0, 0);
    idle(1);
    fault(5, 20, 0, 8'h01, 1, 0, 0, 0);
    idle(1);
    fault(7, 1, 1, 8'h00, 1, 1, 1, 0);
    fault(300, 1, 1, 8'h00, 1, 0, 1, 1);
    idle(1);
    do_reset(2'b00);
    for (int i = 1; i <= 5; i++) begin
      fault(i, 10 + i, 0, 8'h00, 1, 1, i - 1, 0);
      chk("t3_early_term", early_term, ET && i == 5);
    end
    chk("t3_done", done, ET);
    chk("t3_repair", repair, 0);
    fault(6, 16, 0, 8'h00, 0, 0, 0, 0);
    chk("t3_et_sticky", early_term, ET);
    analyze(0, 0);
    do_reset(2'b11);
    sv_force = 1'b1;
    sv_tgt = 12'h02A;
    analyze(43, 1);
    chk("t4_dsss", DSSS, 8'h2A);
    chk("t4_rlss", RLSS, 0);
    fault(1, 1, 0, 8'h00, 0, 0, 0, 0);
    idle(3);
    chk("t4_hold", {done, repair, RLSS, DSSS}, {2'b11, 12'h02A});
    do_reset(2'b11);
    test_end = 1'b1;
    @(posedge clk);
    #1 test_end = 1'b0;
    repeat (99) @(posedge clk);
    #1 chk("t5_cand99", {RLSS, DSSS}, 99);
    chk("t5_not_done", done, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    all_zero("t5_mid_reset");
    analyze(4096, 0);
    chk("t5_cand_max", {RLSS, DSSS}, 12'hFFF);
    for (int j = 0; j < 8; j++) rand_run($urandom_range(8, 45));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
